// File: rtl/ssd_pkg.sv
// Shared constants, segment codes and conversion helpers for the seven-segment scan driver.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package ssd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int VALUE_W    = 13;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } conv_state_t;

  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] digit);
    logic [SEG_W-1:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Bundle between the core's ssd output and the display pins.
// The driver takes the slave side; whatever feeds value takes the master side.
interface ssd_scan_driver_if;
  import ssd_pkg::*;

  logic [VALUE_W-1:0]    value;
  logic [NUM_DIGITS-1:0] anode;
  logic [SEG_W-1:0]      cathode;
  logic                  busy;

  modport master (
    output value,
    input  anode,
    input  cathode,
    input  busy
  );

  modport slave (
    input  value,
    output anode,
    output cathode,
    output busy
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, 13 iterations, then a one-cycle LOAD
// during which done is high and bcd holds the finished digits.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VALUE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  localparam logic [3:0] LAST_ITER = 4'(VALUE_W - 1);

  conv_state_t        state_reg, state_next;
  logic [VALUE_W-1:0] shift_reg, shift_next;
  logic [BCD_W-1:0]   bcd_reg, bcd_next;
  logic [3:0]         iter_reg, iter_next;
  logic [BCD_W-1:0]   bcd_adj;

  always_comb bcd_adj = dabble_adjust(bcd_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      bcd_reg   <= '0;
      iter_reg  <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bcd_reg   <= bcd_next;
      iter_reg  <= iter_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bcd_next   = bcd_reg;
    iter_next  = iter_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next = bin;
          bcd_next   = '0;
          iter_next  = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        {bcd_next, shift_next} = {bcd_adj, shift_reg} << 1;
        iter_next = iter_reg + 4'd1;
        if (iter_reg == LAST_ITER) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == LOAD);
  assign bcd  = bcd_reg;

endmodule

// File: rtl/ssd_scan_driver.sv
// Seven-segment back end: converts the core's binary value to BCD on change and
// time-multiplexes the four digits onto a common-anode display with registered pins.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input logic         clk,
  input logic         rst,
  ssd_scan_driver_if.slave bus
);

  localparam int                CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [VALUE_W-1:0]    src_reg;
  logic [BCD_W-1:0]      disp_reg;
  logic [CNT_W-1:0]      refresh_cnt_reg;
  logic [1:0]            dig_idx_reg;
  logic [NUM_DIGITS-1:0] anode_reg, anode_next;
  logic [SEG_W-1:0]      cathode_reg, cathode_next;

  logic                  conv_start;
  logic                  conv_busy;
  logic                  conv_done;
  logic [BCD_W-1:0]      conv_bcd;
  logic [NUM_DIGITS-1:0] digit_zero;
  logic [NUM_DIGITS-1:0] digit_blank;
  logic [3:0]            cur_digit;

  // value is only looked at while the converter is idle; changes mid-conversion
  // are picked up by the next idle comparison against src_reg.
  assign conv_start = (bus.value != src_reg) && !conv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (bus.value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Digit k is a leading zero when it and every higher digit are zero; digit 0 always shows.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_zero[gi] = (disp_reg[4*gi +: 4] == 4'd0);
    if (gi == 0) begin : g_ones
      assign digit_blank[gi] = 1'b0;
    end else begin : g_upper
      assign digit_blank[gi] = BLANK_LZ && (&digit_zero[NUM_DIGITS-1:gi]);
    end
  end

  always_comb begin
    cur_digit    = disp_reg[{dig_idx_reg, 2'b00} +: 4];
    anode_next   = ~(4'b0001 << dig_idx_reg);
    cathode_next = digit_blank[dig_idx_reg] ? SEG_BLANK : seg_decode(cur_digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_reg         <= '0;
      disp_reg        <= '0;
      refresh_cnt_reg <= '0;
      dig_idx_reg     <= '0;
      anode_reg       <= '1;
      cathode_reg     <= SEG_BLANK;
    end else begin
      if (conv_start) begin
        src_reg <= bus.value;
      end
      if (conv_done) begin
        disp_reg <= conv_bcd;
      end
      if (refresh_cnt_reg == CNT_LAST) begin
        refresh_cnt_reg <= '0;
        dig_idx_reg     <= dig_idx_reg + 2'd1;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + CNT_W'(1);
      end
      anode_reg   <= anode_next;
      cathode_reg <= cathode_next;
    end
  end

  assign bus.anode   = anode_reg;
  assign bus.cathode = cathode_reg;
  assign bus.busy    = conv_busy;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench: two drivers (leading-zero blanking on/off) watch the same value; each
// finished conversion is checked against a decimal-arithmetic model over a scan window.
module tb_ssd_scan_driver;

  localparam int R   = 4;
  localparam int WIN = 3 * R + 1;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] value;

  int errors = 0;
  int checks = 0;
  int cur_src = 0;
  int exp_q [2][$];

  always #5 clk = ~clk;

  ssd_scan_driver_if bus_a ();
  ssd_scan_driver_if bus_b ();

  assign bus_a.value = value;
  assign bus_b.value = value;

  ssd_scan_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  ssd_scan_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic [3:0] anode_s   [2];
  logic [6:0] cathode_s [2];
  logic       busy_s    [2];

  assign anode_s[0]   = bus_a.anode;
  assign anode_s[1]   = bus_b.anode;
  assign cathode_s[0] = bus_a.cathode;
  assign cathode_s[1] = bus_b.cathode;
  assign busy_s[0]    = bus_a.busy;
  assign busy_s[1]    = bus_b.busy;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // Decimal digit idx of v as it should appear on the pins.
  function automatic int exp_seg(input int v, input int idx, input bit blank_lz);
    if (blank_lz && idx > 0 && v < pow10(idx)) return 7'h7f;
    return int'(SEG_TAB[(v / pow10(idx)) % 10]);
  endfunction

  function automatic int anode_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    int scan_left = 0;
    initial begin
      int  run, cur_v, cur_idx, cur_len, idx;
      bit  first_run, prev_busy;
      logic [3:0] seen;
      run = 0; cur_v = 0; cur_idx = -1; cur_len = 0; first_run = 1'b1;
      prev_busy = 1'b0; seen = '0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          run = 0;
          scan_left = 0;
          prev_busy = 1'b0;
        end else begin
          if (scan_left > 0) begin
            idx = anode_idx(anode_s[gi]);
            check($sformatf("anode_onehot[%0d]", gi), int'(idx >= 0), 1);
            if (idx >= 0) begin
              check($sformatf("cathode[%0d] v=%0d d%0d", gi, cur_v, idx),
                    int'(cathode_s[gi]), exp_seg(cur_v, idx, gi == 0));
              seen[idx] = 1'b1;
              if (cur_idx < 0) begin
                cur_idx = idx; cur_len = 1;
              end else if (idx == cur_idx) begin
                cur_len++;
              end else begin
                if (!first_run) check($sformatf("dwell[%0d]", gi), cur_len, R);
                check($sformatf("scan_order[%0d]", gi), idx, (cur_idx + 1) % 4);
                first_run = 1'b0; cur_idx = idx; cur_len = 1;
              end
            end
            scan_left--;
            if (scan_left == 0) check($sformatf("all_digits[%0d]", gi), int'(seen), 4'hf);
          end
          if (busy_s[gi]) begin
            run++;
          end else if (prev_busy) begin
            if (exp_q[gi].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_conv[%0d]: got a conversion, required none", gi);
            end else begin
              cur_v = exp_q[gi].pop_front();
              check($sformatf("busy_len[%0d]", gi), run, 14);
              $display("conv inst=%0d value=%0d busy_len=%0d", gi, cur_v, run);
              scan_left = WIN; seen = '0; cur_idx = -1; cur_len = 0; first_run = 1'b1;
            end
            run = 0;
          end
          prev_busy = busy_s[gi];
        end
      end
    end
  end

  task automatic push_exp(input int v);
    exp_q[0].push_back(v);
    exp_q[1].push_back(v);
  endtask

  task automatic set_value(input int v);
    @(negedge clk);
    value = 13'(v);
    if (v != cur_src) begin
      push_exp(v);
      cur_src = v;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
             g_mon[0].scan_left == 0 && g_mon[1].scan_left == 0 &&
             !busy_s[0] && !busy_s[1]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", int'(n < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!busy_s[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_seen", int'(busy_s[0]), 1);
  endtask

  task automatic check_reset_pins(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_anode[%0d]", tag, i), int'(anode_s[i]), 4'hf);
      check($sformatf("%s_cathode[%0d]", tag, i), int'(cathode_s[i]), 7'h7f);
      check($sformatf("%s_busy[%0d]", tag, i), int'(busy_s[i]), 0);
    end
  endtask

  initial begin
    int dir_vals [8] = '{8191, 7, 0, 10, 100, 1000, 999, 8000};
    int v;

    value = 13'd1234;
    repeat (3) @(negedge clk);
    check_reset_pins("reset");
    push_exp(1234);
    cur_src = 1234;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("busy_first_edge", int'(busy_s[0]), 1);
    check("first_anode", int'(anode_s[0]), 4'b1110);
    check("first_cathode", int'(cathode_s[0]), 7'b1000000);
    wait_idle();

    foreach (dir_vals[i]) begin
      set_value(dir_vals[i]);
      wait_idle();
    end

    // Same value again must not start a conversion.
    set_value(cur_src);
    repeat (30) @(negedge clk);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(0, 8191));
      set_value(v);
      wait_idle();
    end

    // Change mid-conversion: 500 finishes, then 42 is converted.
    set_value(500);
    wait_busy();
    repeat (3) @(negedge clk);
    value = 13'd42;
    push_exp(42);
    cur_src = 42;
    wait_idle();

    // Reset mid-conversion aborts 3333; 9 is converted after release.
    set_value(3333);
    wait_busy();
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_pins("midreset");
    exp_q[0].delete();
    exp_q[1].delete();
    value = 13'd9;
    push_exp(9);
    cur_src = 9;
    @(negedge clk);
    #2 rst = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Seven-segment display back end for `RISCV_pipeline`. Consumes the 13-bit `ssd` value the core produces and converts it to four BCD digits with a multi-cycle sequential double-dabble converter. Time-multiplexes the four digits onto the board's common-anode display. Sits directly downstream of the core at board top level, between the core's `ssd` output and the physical anode/cathode pins.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Legal range is ≥ 2.
- `BLANK_LZ`, default 1: when 1, leading-zero digits are blanked. Digit 0 is never blanked.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `value`  in  13  unsigned binary from the core's `ssd` output, range 0–8191.
- `anode`  out  4  digit enables, active-low; bit 0 is the ones digit.
- `cathode`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- **Registers:** `src` (13 b, last value converted), `disp` (4×4 b BCD digits shown), `refresh_cnt`, `dig_idx` (2 b), FSM.
- **FSM states:** `IDLE`, `CONV`, `LOAD`.
  - `IDLE`: if `value != src`, capture `value` into the shift register, clear the BCD accumulator, set `src <= value`, go to `CONV`.
  - `CONV`: 13 iterations, one per cycle. In each iteration, add 3 to every BCD nibble ≥ 5, then shift `{bcd, bin}` left by 1. Go to `LOAD` after iteration 13.
  - `LOAD`: `disp <= bcd`, go to `IDLE`.
- **Changes during a conversion:** `value` changes during `CONV`/`LOAD` are not sampled. The next `IDLE` cycle compares against `src` and restarts, so the final displayed value always equals the last stable `value`.
- **Digit scan:**
  - `refresh_cnt` counts 0 to `REFRESH_DIV-1` and then wraps.
  - On each wrap, `dig_idx` increments modulo 4: 0→1→2→3→0.
- **Outputs:** `anode` and `cathode` are registered every cycle from `dig_idx` and `disp[dig_idx]`.
  - `anode` = one-hot-low of `dig_idx`.
  - `cathode` = segment code for the digit.
- **Segment codes (active-low `gfedcba`):**
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - blank: 1111111
- **Blanking:** with `BLANK_LZ=1`, digit k (k ≥ 1) is blanked when digits k..3 of `disp` are all zero. The anode is still driven low; only the cathode is blanked.
- **Range:** thousands digit never exceeds 8; BCD nibbles never exceed 9.

## Timing
- **Reset values (asynchronous, while `rst=0`):**
  - `anode=4'b1111`, `cathode=7'b1111111`, `busy=0`
  - `src=0`, `disp=0`, `refresh_cnt=0`, `dig_idx=0`, state `IDLE`
- **After reset release:**
  - The first rising edge drives `anode=1110`, `cathode=1000000` ("0").
  - No conversion starts if `value=0`.
- **Conversion latency:**
  - `value` is captured at edge E.
  - `busy=1` from after edge E until after edge E+14.
  - `disp` updates at edge E+14.
  - Pins reflect the new digits at edge E+15 (output register).
- **Per-digit dwell:** exactly `REFRESH_DIV` cycles. A full scan is `4·REFRESH_DIV` cycles.
- **Reset mid-conversion:** aborts immediately and all reset values apply. The pending value is reconverted after release if `value != 0`.
- **Simultaneous digit advance and `LOAD`:** the new `disp` is used from the following edge; no glitch is permitted beyond one cycle of old data.

## Structure
- **Shared package `ssd_pkg`:**
  - `NUM_DIGITS=4`, `VALUE_W=13`
  - The ten segment-code constants and `SEG_BLANK`
  - The FSM state encoding
- **Sub-module `bin2bcd_seq`:** the `CONV` datapath plus FSM. Ports: `clk`, `rst`, `start`, `bin[12:0]`, `busy`, `done`, `bcd[15:0]`.
- **Top `ssd_scan_driver`:** change detection, refresh counter, blanking and segment decode.

## Test plan
Bench uses `REFRESH_DIV=4` unless stated otherwise.
- **Reset:** hold `rst=0` with `value=1234` → `anode=1111`, `cathode=1111111`, `busy=0`. After release, `busy` rises at the first edge and `disp=0x1234` at edge 14.
- **Scan of 1234:** after the conversion, the `anode` sequence is 1110/1101/1011/0111 with 4 cycles each. `cathode` is 0011001/0110000/0100100/1111001 respectively.
- **Maximum value 8191:** `disp=0x8191`; thousands digit `cathode=0000000`.
- **Blanking of 7:** with `BLANK_LZ=1`, digit 0 `cathode=1111000` and digits 1–3 `cathode=1111111` with anodes still cycling. With `BLANK_LZ=0`, digits 1–3 show 1000000.
- **Change during conversion:** change `value` from 500 to 42 three cycles into `CONV`. `disp` first becomes 0x0500, then a second conversion gives 0x0042. Two `busy` pulses of 14 cycles each.
- **Reset mid-conversion:** pulse `rst` low during `CONV` → outputs go to reset values immediately. After release, `value=9` converts to `disp=0x0009`.
